// File: rtl/serial_negator_array_pkg.sv
// Shared definitions for the serial two's-complement converter: lane state
// encoding and the bit-counter width helper.
package serial_negator_array_pkg;

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } lane_state_e;

  // Width of a counter spanning 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_negator_array_lane.sv
// One lane of the serial negator: COPY/INVERT FSM, per-word mode register,
// and the combinational output bit / overflow flag for the current input bit.
module serial_negator_lane
  import serial_negator_array_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sync_clr,
  input  logic in_valid,
  input  logic first,
  input  logic last,
  input  logic in_bit,
  input  logic negate,
  output logic out_bit,
  output logic ovf,
  output logic state_dbg
);

  lane_state_e state_q, state_d;
  logic        mode_q, mode_d;
  logic        mode_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COPY;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    // Bit 0 must already act on the new word's mode, before the latch updates.
    mode_eff = first ? negate : mode_q;
    out_bit  = (mode_eff && (state_q == INVERT)) ? ~in_bit : in_bit;
    ovf      = mode_eff && (state_q == COPY) && last && in_bit;

    if (sync_clr) begin
      state_d = COPY;
    end else if (in_valid) begin
      if (first) mode_d = negate;
      if (last) begin
        state_d = COPY;
      end else if (in_bit) begin
        state_d = INVERT;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/serial_negator_array.sv
// Multi-lane LSB-first serial converter: each lane passes or negates WIDTH-bit
// words, with shared word framing and registered outputs (1-cycle latency).
module serial_negator_array
  import serial_negator_array_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync_clr,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] in_bit,
  input  logic [CHANNELS-1:0] negate,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_bit,
  output logic                out_last,
  output logic [CHANNELS-1:0] ovf,
  output logic [CHANNELS-1:0] dbg_lane_state
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [CHANNELS-1:0] out_bit_q, out_bit_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] lane_out, lane_ovf;
  logic                first, last, accept;

  assign first  = (bit_cnt_q == '0);
  assign last   = (bit_cnt_q == CW'(WIDTH - 1));
  assign accept = in_valid && !sync_clr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    serial_negator_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .sync_clr  (sync_clr),
      .in_valid  (in_valid),
      .first     (first),
      .last      (last),
      .in_bit    (in_bit[i]),
      .negate    (negate[i]),
      .out_bit   (lane_out[i]),
      .ovf       (lane_ovf[i]),
      .state_dbg (dbg_lane_state[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bit_q   <= '0;
      ovf_q       <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bit_q   <= out_bit_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    out_valid_d = accept;
    out_last_d  = accept && last;
    out_bit_d   = out_bit_q;
    ovf_d       = '0;

    if (sync_clr) begin
      bit_cnt_d = '0;
      out_bit_d = '0;
    end else if (in_valid) begin
      bit_cnt_d = last ? '0 : bit_cnt_q + CW'(1);
      out_bit_d = lane_out;
      if (last) ovf_d = lane_ovf;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_bit   = out_bit_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_negator_array.sv
// Bench for serial_negator_array: word-level negation model feeding an
// expected queue, with an independent monitor comparing each output cycle.
module tb_serial_negator_array;

  localparam int W  = 4;
  localparam int C  = 2;
  localparam int EW = 2 * C + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sync_clr = 1'b0;
  logic         in_valid = 1'b0;
  logic [C-1:0] in_bit = '0;
  logic [C-1:0] negate = '0;
  logic         out_valid;
  logic [C-1:0] out_bit;
  logic         out_last;
  logic [C-1:0] ovf;
  logic [C-1:0] dbg_lane_state;

  serial_negator_array #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk            (clk),
    .reset          (reset),
    .sync_clr       (sync_clr),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .negate         (negate),
    .out_valid      (out_valid),
    .out_bit        (out_bit),
    .out_last       (out_last),
    .ovf            (ovf),
    .dbg_lane_state (dbg_lane_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: entries are {out_bit, ovf, out_last}.
  logic [EW-1:0] exp_q[$];
  logic [C-1:0]  exp_hold = '0;
  int            checks = 0;
  int            errors = 0;

  // Reference model state: position in word, bits received so far, word mode.
  int   idx = 0;
  int   prefix [C];
  logic mode   [C];

  task automatic model_clear(input bit clr_mode);
    idx = 0;
    for (int l = 0; l < C; l++) begin
      prefix[l] = 0;
      if (clr_mode) mode[l] = 1'b0;
    end
  endtask

  task automatic send_bit(input logic [C-1:0] b, input logic [C-1:0] n);
    logic [C-1:0] eb;
    logic [C-1:0] eo;
    logic         el;
    @(negedge clk); #1;
    sync_clr = 1'b0;
    in_valid = 1'b1;
    in_bit   = b;
    negate   = n;
    el = (idx == W - 1);
    for (int l = 0; l < C; l++) begin
      if (idx == 0) mode[l] = n[l];
      prefix[l] = prefix[l] | (int'(b[l]) << idx);
      // Bit idx of -x depends only on x[idx:0].
      eb[l] = mode[l] ? 1'(((-prefix[l]) >> idx) & 1) : b[l];
      eo[l] = el && mode[l] && (prefix[l] == (1 << (W - 1)));
    end
    exp_q.push_back({eb, eo, el});
    if (el) model_clear(1'b0);
    else idx++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      sync_clr = 1'b0;
      in_valid = 1'b0;
      in_bit   = C'($urandom);
      negate   = C'($urandom);
    end
  endtask

  task automatic do_sync_clr();
    @(negedge clk); #1;
    sync_clr = 1'b1;
    in_valid = 1'($urandom);
    in_bit   = C'($urandom);
    negate   = C'($urandom);
    exp_hold = '0;
    model_clear(1'b0);
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({out_valid, out_bit, out_last, ovf} !== '0) begin
      errors++;
      $display("FAIL %s: got valid=%b bit=%b last=%b ovf=%b, need all zero",
               name, out_valid, out_bit, out_last, ovf);
    end
  endtask

  task automatic do_reset_mid();
    @(negedge clk); #1;
    in_valid = 1'b0;
    sync_clr = 1'b0;
    reset    = 1'b0;
    #2;
    check_zero_outputs("async_reset");
    exp_q.delete();
    exp_hold = '0;
    model_clear(1'b1);
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  // Monitor: pops on every valid output; otherwise checks idle outputs.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got bit=%b last=%b ovf=%b, need no output",
                   out_bit, out_last, ovf);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          exp_hold = e[EW-1 -: C];
          if ({out_bit, ovf, out_last} !== e) begin
            errors++;
            $display("FAIL out_word_bit: got bit=%b ovf=%b last=%b, need bit=%b ovf=%b last=%b",
                     out_bit, ovf, out_last, e[EW-1 -: C], e[C:1], e[0]);
          end
        end
      end else begin
        checks++;
        if ({out_bit, ovf, out_last} !== {exp_hold, {C{1'b0}}, 1'b0}) begin
          errors++;
          $display("FAIL idle_out: got bit=%b ovf=%b last=%b, need bit=%b ovf=0 last=0",
                   out_bit, ovf, out_last, exp_hold);
        end
      end
    end
  end

  initial begin
    model_clear(1'b1);
    #3;
    check_zero_outputs("reset_state");
    @(negedge clk); #1;
    reset = 1'b1;

    // 6 negated -> 1010; then -8 (overflow) and 0 on both lanes.
    send_bit(2'b00, 2'b11); send_bit(2'b11, 2'b11);
    send_bit(2'b11, 2'b11); send_bit(2'b00, 2'b11);
    send_bit(2'b00, 2'b11); send_bit(2'b00, 2'b11);
    send_bit(2'b00, 2'b11); send_bit(2'b01, 2'b11);

    // Lane 0 pass, lane 1 negate on 5; back-to-back second word with a mid-word negate toggle.
    send_bit(2'b11, 2'b10); send_bit(2'b00, 2'b10);
    send_bit(2'b11, 2'b10); send_bit(2'b00, 2'b10);
    send_bit(2'b11, 2'b10); send_bit(2'b00, 2'b01);
    send_bit(2'b11, 2'b01); send_bit(2'b00, 2'b01);

    // Gaps mid-word: 1,1,0,0 with three idle cycles before the third bit.
    send_bit(2'b11, 2'b11); send_bit(2'b11, 2'b11);
    idle(3);
    send_bit(2'b00, 2'b11); send_bit(2'b00, 2'b11);

    // Reset after two bits, then a fresh word 0,1,0,0 negated.
    send_bit(2'b11, 2'b11); send_bit(2'b10, 2'b11);
    do_reset_mid();
    send_bit(2'b00, 2'b11); send_bit(2'b11, 2'b11);
    send_bit(2'b00, 2'b11); send_bit(2'b00, 2'b11);

    // sync_clr after three bits, then a newly framed word.
    send_bit(2'b11, 2'b11); send_bit(2'b00, 2'b11); send_bit(2'b00, 2'b11);
    do_sync_clr();
    send_bit(2'b00, 2'b11); send_bit(2'b00, 2'b11);
    send_bit(2'b00, 2'b11); send_bit(2'b11, 2'b11);

    // Randomised traffic with gaps and occasional restarts.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) do_sync_clr();
      else if (r < 5) idle($urandom_range(1, 3));
      else send_bit(C'($urandom), C'($urandom));
    end

    idle(1);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs pending, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_negator_array.md
# serial_negator_array

Parametrised, multi-channel, word-framed serial two's-complement converter. CHANNELS independent lanes accept LSB-first bit streams of WIDTH-bit words and, per lane and per word, either pass the word through or negate it. Every WIDTH valid bits the block closes the word, flags negation overflow, and re-arms automatically. It sits between a serial source and downstream serial consumers, with registered outputs.

## Interface
- WIDTH, 8: bits per word, >= 2.
- CHANNELS, 1: number of parallel lanes, >= 1.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sync_clr  in  1  synchronous word restart; has priority over in_valid.
- in_valid  in  1  qualifies in_bit for all lanes this cycle.
- in_bit  in  CHANNELS  serial data, LSB first, one bit per lane.
- negate  in  CHANNELS  per-lane mode: 1 = negate, 0 = pass. Sampled on bit 0 of each word.
- out_valid  out  1  registered copy of the accepted in_valid.
- out_bit  out  CHANNELS  converted bits.
- out_last  out  1  high with out_valid on the last bit (bit WIDTH-1) of a word.
- ovf  out  CHANNELS  per-lane negation overflow. Valid only while out_last=1; 0 otherwise.

## Operation
- Shared bit counter bit_cnt, $clog2(WIDTH) bits, range 0..WIDTH-1. Increments on each in_valid cycle. Wraps to 0 after WIDTH-1.
- Per-lane FSM with two states:
  - COPY: no 1 seen yet in this word.
  - INVERT: a 1 has been seen.
- Per-lane mode register:
  - Loaded from negate[i] on an in_valid cycle with bit_cnt=0.
  - Bit 0 uses live negate[i]; bits 1..WIDTH-1 use the latched value.
- Output bit:
  - Pass mode: out = in.
  - Negate mode, state COPY: out = in.
  - Negate mode, state INVERT: out = ~in.
- Transitions, on in_valid only:
  - COPY -> INVERT when in_bit=1 and this is not the last bit.
  - On the last bit, every lane returns to COPY regardless of input.
- Overflow: ovf[i]=1 when the lane is in negate mode, the state is COPY at the last bit, and in_bit=1 (input is -2^(WIDTH-1)). The output then equals the input. Zero input gives no overflow.
- in_valid=0: no state or counter change. out_valid=0, out_last=0, ovf=0. out_bit holds its previous value.
- sync_clr=1: bit_cnt=0, all lanes go to COPY, outputs go to their reset values next cycle. Any in_valid in the same cycle is dropped.
- reset low, at any time including mid-word:
  - bit_cnt=0, all lanes COPY, mode=0.
  - out_valid=0, out_bit=0, out_last=0, ovf=0.
  - After release, the first valid bit is bit 0.

## Timing
- Latency 1 cycle: an in_valid bit sampled at edge k appears on out_* after edge k.
- Throughput: one bit per lane per cycle. Back-to-back words need no idle cycle.
- in_valid gaps of any length are allowed mid-word; framing is preserved.
- out_last and ovf assert for exactly one out_valid cycle per word.
- Reset asserts asynchronously and releases synchronously to the clk domain. Release is the integrator's responsibility.

## Structure
- Shared package/header holds:
  - lane state encoding: COPY=1'b0, INVERT=1'b1.
  - the counter-width function.
- Sub-module serial_negator_lane holds one lane's FSM, mode register, output and ovf logic. Its inputs are bit-0/last-bit strobes from the top-level counter.
- The top level holds bit_cnt, sync_clr/reset handling, a generate loop over CHANNELS, and the output registers.

## Test plan
- WIDTH=4, negate=1, bits 0,1,1,0 (6) -> out 0,1,0,1 (-6, 1010); out_last on 4th; ovf=0.
- WIDTH=4, negate=1, bits 0,0,0,1 (-8) -> out 0,0,0,1; ovf=1 with out_last. Bits 0,0,0,0 -> 0,0,0,0, ovf=0.
- CHANNELS=2, lane0 negate=0 / lane1 negate=1, both fed 1,0,1,0 (5):
  - lane0 -> 1,0,1,0; lane1 -> 1,1,0,1 (1011, -5).
  - Second word immediately after restarts in COPY.
  - Toggle negate mid-word -> no effect until the next bit 0.
- in_valid gaps: word 1,1,0,0 with 3 idle cycles between bits 2 and 3 -> out 1,0,1,1, out_last on the 4th valid output. out_valid=0 during gaps with out_bit held.
- Reset mid-word: assert reset low after 2 bits -> all outputs 0 immediately. After release, word 0,1,0,0 negate=1 -> 0,1,1,1 with fresh framing.
- sync_clr after 3 bits of 1,0,0 -> next cycle out_valid=0. Following 4 bits are framed as a new word.
